hazard_ctrl: RTL and testbench

- Central pipeline controller for the 5-stage RV32I pipeline.
- Tracks destination/source register fields of in-flight instructions in its own EX/MEM/WB scoreboard. The scoreboard mirrors the IR buffer chain, and its rd = instr[11:7] matches what the IR buffers carry.
- Generates PC/IF-ID enables, IF-ID and ID-EX flushes, and ALU operand forwarding selects.
- Sequences load-use stalls, taken-branch/jump flushes and FENCE drains.

---
 rtl/riscv_pipe_pkg.sv | 53 +++++
 rtl/hazard_ctrl_if.sv | 24 ++
 rtl/instr_field_dec.sv | 40 ++++
 rtl/hazard_ctrl.sv | 101 ++++++++++
 tb/tb_hazard_ctrl.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pipe_pkg.sv
// Shared types for the RV32I pipeline control path: opcode constants,
// forwarding-select and hazard-FSM encodings, and the scoreboard entry layout.
package riscv_pipe_pkg;

  localparam int XLEN      = 32;
  localparam int RF_ADDR_W = 5;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } hz_state_e;

  typedef struct packed {
    logic                 valid;
    logic [RF_ADDR_W-1:0] rd;
    logic                 wr;
    logic                 is_load;
    logic [RF_ADDR_W-1:0] rs1;
    logic [RF_ADDR_W-1:0] rs2;
    logic                 use1;
    logic                 use2;
  } sb_entry_t;

  // A load still in MEM has no data yet, so only WB may forward a load result.
  function automatic fwd_sel_e fwd_pick(sb_entry_t mem, sb_entry_t wb,
                                        logic [RF_ADDR_W-1:0] rs, logic use_r);
    fwd_sel_e sel;
    sel = FWD_RF;
    if (use_r && mem.valid && mem.wr && !mem.is_load && (mem.rd == rs))
      sel = FWD_MEM;
    else if (use_r && wb.valid && wb.wr && (wb.rd == rs))
      sel = FWD_WB;
    return sel;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle. The datapath is the master
// (presents the ID instruction and redirect), the controller is the slave.
interface hazard_ctrl_if #(parameter int XLEN = 32);
  logic [XLEN-1:0] id_instr;
  logic            id_valid;
  logic            ex_redirect;
  logic            pc_en;
  logic            ifid_en;
  logic            ifid_flush;
  logic            idex_flush;
  logic [1:0]      fwd_a_sel;
  logic [1:0]      fwd_b_sel;
  logic            drain_busy;

  modport master (
    output id_instr, id_valid, ex_redirect,
    input  pc_en, ifid_en, ifid_flush, idex_flush, fwd_a_sel, fwd_b_sel, drain_busy
  );

  modport slave (
    input  id_instr, id_valid, ex_redirect,
    output pc_en, ifid_en, ifid_flush, idex_flush, fwd_a_sel, fwd_b_sel, drain_busy
  );
endinterface

// File: rtl/instr_field_dec.sv
// Combinational decode of one instruction into a scoreboard entry.
// An invalid slot decodes to an all-zero (bubble) entry.
module instr_field_dec
  import riscv_pipe_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int RF_ADDR_W = 5
) (
  input  logic [XLEN-1:0] instr,
  input  logic            valid,
  output sb_entry_t       entry,
  output logic            is_fence
);

  logic [6:0] opcode;
  logic       writes;
  logic       unused_bits;

  assign opcode      = instr[6:0];
  assign unused_bits = ^{instr[XLEN-1:25], instr[14:12]};

  always_comb begin
    entry    = '0;
    is_fence = 1'b0;
    writes   = opcode inside {OP_R, OP_IALU, OP_LOAD, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    if (valid) begin
      entry.valid   = 1'b1;
      entry.rd      = instr[7 +: RF_ADDR_W];
      entry.rs1     = instr[15 +: RF_ADDR_W];
      entry.rs2     = instr[20 +: RF_ADDR_W];
      // x0 is hardwired, so a write to it must never look like a producer.
      entry.wr      = writes && (instr[7 +: RF_ADDR_W] != '0);
      entry.is_load = (opcode == OP_LOAD);
      entry.use1    = opcode inside {OP_R, OP_IALU, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR};
      entry.use2    = opcode inside {OP_R, OP_STORE, OP_BRANCH};
      is_fence      = (opcode == OP_FENCE);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Central hazard controller: EX/MEM/WB scoreboard, load-use stall, redirect
// flush, FENCE drain FSM and operand forwarding selects (all zero-latency).
module hazard_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int RF_ADDR_W = 5
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave hz
);

  sb_entry_t ex_q, mem_q, wb_q, id_dec;
  logic      id_fence;
  hz_state_e state_q, state_d;
  logic      any_busy, load_use, advance;
  logic      pc_en, ifid_en, ifid_flush, idex_flush;
  fwd_sel_e  fwd_a, fwd_b;
  logic      unused_wb;

  instr_field_dec #(
    .XLEN      (XLEN),
    .RF_ADDR_W (RF_ADDR_W)
  ) u_id_dec (
    .instr    (hz.id_instr),
    .valid    (hz.id_valid),
    .entry    (id_dec),
    .is_fence (id_fence)
  );

  assign any_busy  = ex_q.valid | mem_q.valid | wb_q.valid;
  assign load_use  = ex_q.valid & ex_q.is_load & ex_q.wr &
                     ((id_dec.use1 & (id_dec.rs1 == ex_q.rd)) |
                      (id_dec.use2 & (id_dec.rs2 == ex_q.rd)));
  assign fwd_a     = fwd_pick(mem_q, wb_q, ex_q.rs1, ex_q.use1);
  assign fwd_b     = fwd_pick(mem_q, wb_q, ex_q.rs2, ex_q.use2);
  assign unused_wb = ^{wb_q.is_load, wb_q.rs1, wb_q.rs2, wb_q.use1, wb_q.use2};

  // Redirect outranks everything; a drain or load-use stall holds PC/IF-ID and
  // sends a bubble to EX. "advance" means the ID instruction moves into EX.
  always_comb begin
    state_d    = state_q;
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    advance    = 1'b1;
    if (hz.ex_redirect) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      advance    = 1'b0;
      state_d    = RUN;
    end else begin
      unique case (state_q)
        DRAIN: begin
          if (any_busy) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            advance    = 1'b0;
          end else begin
            state_d = RUN;
          end
        end
        default: begin
          if ((id_fence && any_busy) || load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            advance    = 1'b0;
          end
          if (id_fence && any_busy) state_d = DRAIN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      wb_q    <= mem_q;
      mem_q   <= ex_q;
      ex_q    <= advance ? id_dec : '0;
    end
  end

  assign hz.pc_en      = rst ? 1'b0  : pc_en;
  assign hz.ifid_en    = rst ? 1'b0  : ifid_en;
  assign hz.ifid_flush = rst ? 1'b1  : ifid_flush;
  assign hz.idex_flush = rst ? 1'b1  : idex_flush;
  assign hz.fwd_a_sel  = rst ? 2'b00 : fwd_a;
  assign hz.fwd_b_sel  = rst ? 2'b00 : fwd_b;
  assign hz.drain_busy = rst ? 1'b0  : (state_q == DRAIN);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scenarios plus randomized traffic for hazard_ctrl, checked every
// cycle against a pipeline-level model of the hazard rules.
module tb_hazard_ctrl;

  localparam logic [6:0] T_R = 7'b0110011, T_I = 7'b0010011, T_LD = 7'b0000011;
  localparam logic [6:0] T_ST = 7'b0100011, T_BR = 7'b1100011, T_JALR = 7'b1100111;
  localparam logic [6:0] T_JAL = 7'b1101111, T_LUI = 7'b0110111, T_AUIPC = 7'b0010111;
  localparam logic [6:0] T_FENCE = 7'b0001111;
  localparam logic [31:0] NOP_W = 32'h00000013;
  localparam logic [31:0] FENCE_W = 32'h0FF0000F;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.XLEN(32)) hz ();

  hazard_ctrl #(.XLEN(32), .RF_ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // Model: instruction words in EX/MEM/WB (index 0/1/2) and a drain flag.
  logic [31:0] m_ins [3];
  bit          m_v   [3];
  bit          m_drain;
  bit          exp_pc, exp_ifid, exp_iff, exp_idf, exp_db;
  logic [1:0]  exp_fa, exp_fb;

  function automatic bit reads1(logic [31:0] x);
    return x[6:0] inside {T_R, T_I, T_LD, T_ST, T_BR, T_JALR};
  endfunction

  function automatic bit reads2(logic [31:0] x);
    return x[6:0] inside {T_R, T_ST, T_BR};
  endfunction

  function automatic bit writes(logic [31:0] x);
    return (x[6:0] inside {T_R, T_I, T_LD, T_JAL, T_JALR, T_LUI, T_AUIPC}) && (x[11:7] != 5'd0);
  endfunction

  function automatic logic [1:0] model_fwd(int k);
    logic [1:0] r;
    logic [4:0] src;
    bit         uses;
    r    = 2'b00;
    src  = (k == 1) ? m_ins[0][19:15] : m_ins[0][24:20];
    uses = (k == 1) ? reads1(m_ins[0]) : reads2(m_ins[0]);
    if (m_v[0] && uses) begin
      if (m_v[1] && writes(m_ins[1]) && m_ins[1][11:7] == src && m_ins[1][6:0] != T_LD)
        r = 2'b01;
      else if (m_v[2] && writes(m_ins[2]) && m_ins[2][11:7] == src)
        r = 2'b10;
    end
    return r;
  endfunction

  function automatic logic [31:0] enc_r(int rd, int rs1, int rs2, bit sub);
    logic [6:0] f7;
    f7 = sub ? 7'b0100000 : 7'b0000000;
    return {f7, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), T_R};
  endfunction

  function automatic logic [31:0] enc_i(int rd, int rs1, int imm);
    return {12'(imm), 5'(rs1), 3'b000, 5'(rd), T_I};
  endfunction

  function automatic logic [31:0] enc_lw(int rd, int rs1);
    return {12'd0, 5'(rs1), 3'b010, 5'(rd), T_LD};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] op;
    case ($urandom_range(0, 10))
      0: op = T_R;   1: op = T_I;   2: op = T_LD;  3: op = T_ST;
      4: op = T_BR;  5: op = T_JALR; 6: op = T_JAL; 7: op = T_LUI;
      8: op = T_AUIPC; 9: op = T_FENCE; default: op = T_LD;
    endcase
    return {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            3'($urandom), 5'($urandom_range(0, 3)), op};
  endfunction

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", name, cycle, act, want);
    end
  endtask

  task automatic compareModel();
    logic [31:0] id;
    bit busy, fence, lu, stall, nxt_drain;
    id    = hz.id_instr;
    busy  = m_v[0] || m_v[1] || m_v[2];
    fence = hz.id_valid && id[6:0] == T_FENCE;
    lu    = hz.id_valid && m_v[0] && m_ins[0][6:0] == T_LD && writes(m_ins[0]) &&
            ((reads1(id) && id[19:15] == m_ins[0][11:7]) ||
             (reads2(id) && id[24:20] == m_ins[0][11:7]));
    stall     = 1'b0;
    nxt_drain = m_drain;
    if (hz.ex_redirect) nxt_drain = 1'b0;
    else if (m_drain) begin
      if (busy) stall = 1'b1;
      else nxt_drain = 1'b0;
    end else if (fence && busy) begin
      stall     = 1'b1;
      nxt_drain = 1'b1;
    end else if (lu) stall = 1'b1;

    if (rst) begin
      exp_pc = 0; exp_ifid = 0; exp_iff = 1; exp_idf = 1; exp_fa = 0; exp_fb = 0; exp_db = 0;
    end else begin
      exp_pc   = !stall;
      exp_ifid = !stall;
      exp_iff  = hz.ex_redirect;
      exp_idf  = hz.ex_redirect || stall;
      exp_fa   = model_fwd(1);
      exp_fb   = model_fwd(2);
      exp_db   = m_drain;
    end
    checkOutput("model_pc_en", hz.pc_en, exp_pc);
    checkOutput("model_ifid_en", hz.ifid_en, exp_ifid);
    checkOutput("model_ifid_flush", hz.ifid_flush, exp_iff);
    checkOutput("model_idex_flush", hz.idex_flush, exp_idf);
    checkOutput("model_fwd_a", hz.fwd_a_sel, exp_fa);
    checkOutput("model_fwd_b", hz.fwd_b_sel, exp_fb);
    checkOutput("model_drain_busy", hz.drain_busy, exp_db);

    if (rst) begin
      for (int k = 0; k < 3; k++) m_v[k] = 1'b0;
      m_drain = 1'b0;
    end else begin
      m_v[2] = m_v[1]; m_ins[2] = m_ins[1];
      m_v[1] = m_v[0]; m_ins[1] = m_ins[0];
      m_v[0] = hz.id_valid && !stall && !hz.ex_redirect;
      m_ins[0] = id;
      m_drain = nxt_drain;
    end
  endtask

  task automatic applyStimulus(bit r, logic [31:0] ins, bit v, bit redir);
    @(posedge clk);
    #1;
    rst            = r;
    hz.id_instr    = ins;
    hz.id_valid    = v;
    hz.ex_redirect = redir;
    @(negedge clk);
    cycle++;
    compareModel();
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) applyStimulus(0, NOP_W, 0, 0);
  endtask

  initial begin
    logic [31:0] cur_ins;
    bit cur_v, hold, r, rd_x;
    rst = 1'b1;
    hz.id_instr = NOP_W;
    hz.id_valid = 1'b0;
    hz.ex_redirect = 1'b0;
    m_drain = 1'b0;
    for (int k = 0; k < 3; k++) begin m_v[k] = 1'b0; m_ins[k] = NOP_W; end

    applyStimulus(1, NOP_W, 0, 0);
    checkOutput("rst_pc_en", hz.pc_en, 0);
    checkOutput("rst_ifid_en", hz.ifid_en, 0);
    checkOutput("rst_ifid_flush", hz.ifid_flush, 1);
    checkOutput("rst_idex_flush", hz.idex_flush, 1);
    applyStimulus(1, NOP_W, 0, 0);
    applyStimulus(0, NOP_W, 0, 0);
    checkOutput("run_pc_en", hz.pc_en, 1);
    checkOutput("run_ifid_en", hz.ifid_en, 1);
    checkOutput("run_ifid_flush", hz.ifid_flush, 0);
    checkOutput("run_idex_flush", hz.idex_flush, 0);

    // add x5,x1,x2 ; sub x6,x5,x3
    applyStimulus(0, enc_r(5, 1, 2, 0), 1, 0);
    applyStimulus(0, enc_r(6, 5, 3, 1), 1, 0);
    applyStimulus(0, NOP_W, 0, 0);
    checkOutput("alu_fwd_a", hz.fwd_a_sel, 2'b01);
    checkOutput("alu_fwd_b", hz.fwd_b_sel, 2'b00);
    checkOutput("alu_no_stall", hz.pc_en, 1);
    idle(3);

    // lw x5,0(x1) ; add x6,x5,x5
    applyStimulus(0, enc_lw(5, 1), 1, 0);
    applyStimulus(0, enc_r(6, 5, 5, 0), 1, 0);
    checkOutput("lu_pc_en", hz.pc_en, 0);
    checkOutput("lu_ifid_en", hz.ifid_en, 0);
    checkOutput("lu_idex_flush", hz.idex_flush, 1);
    applyStimulus(0, enc_r(6, 5, 5, 0), 1, 0);
    checkOutput("lu_one_cycle", hz.pc_en, 1);
    applyStimulus(0, NOP_W, 0, 0);
    checkOutput("lu_fwd_a", hz.fwd_a_sel, 2'b10);
    checkOutput("lu_fwd_b", hz.fwd_b_sel, 2'b10);
    idle(3);

    // addi x0,x1,1 ; add x2,x0,x0
    applyStimulus(0, enc_i(0, 1, 1), 1, 0);
    applyStimulus(0, enc_r(2, 0, 0, 0), 1, 0);
    applyStimulus(0, NOP_W, 0, 0);
    checkOutput("x0_fwd_a", hz.fwd_a_sel, 2'b00);
    checkOutput("x0_fwd_b", hz.fwd_b_sel, 2'b00);
    idle(3);

    // load-use hazard coinciding with a redirect
    applyStimulus(0, enc_lw(5, 1), 1, 0);
    applyStimulus(0, enc_r(6, 5, 0, 0), 1, 1);
    checkOutput("redir_pc_en", hz.pc_en, 1);
    checkOutput("redir_ifid_flush", hz.ifid_flush, 1);
    checkOutput("redir_idex_flush", hz.idex_flush, 1);
    applyStimulus(0, NOP_W, 0, 0);
    checkOutput("redir_no_extra", hz.pc_en, 1);
    idle(3);

    // three ALU ops then a fence: 3 stall cycles, drain_busy 3 cycles
    applyStimulus(0, enc_i(1, 0, 1), 1, 0);
    applyStimulus(0, enc_i(2, 0, 2), 1, 0);
    applyStimulus(0, enc_i(3, 0, 3), 1, 0);
    applyStimulus(0, FENCE_W, 1, 0);
    checkOutput("fence_t0_pc_en", hz.pc_en, 0);
    checkOutput("fence_t0_busy", hz.drain_busy, 0);
    for (int k = 1; k <= 2; k++) begin
      applyStimulus(0, FENCE_W, 1, 0);
      checkOutput("fence_drain_busy", hz.drain_busy, 1);
      checkOutput("fence_drain_pc_en", hz.pc_en, 0);
    end
    applyStimulus(0, FENCE_W, 1, 0);
    checkOutput("fence_exit_busy", hz.drain_busy, 1);
    checkOutput("fence_exit_pc_en", hz.pc_en, 1);
    applyStimulus(0, NOP_W, 0, 0);
    checkOutput("fence_run_busy", hz.drain_busy, 0);
    idle(3);

    // reset while draining
    applyStimulus(0, enc_i(1, 0, 1), 1, 0);
    applyStimulus(0, enc_i(2, 0, 2), 1, 0);
    applyStimulus(0, enc_i(3, 0, 3), 1, 0);
    applyStimulus(0, FENCE_W, 1, 0);
    applyStimulus(0, FENCE_W, 1, 0);
    checkOutput("rdrain_busy", hz.drain_busy, 1);
    applyStimulus(1, FENCE_W, 1, 0);
    checkOutput("rdrain_rst_pc_en", hz.pc_en, 0);
    checkOutput("rdrain_rst_ifid_flush", hz.ifid_flush, 1);
    applyStimulus(0, FENCE_W, 1, 0);
    checkOutput("rdrain_run_busy", hz.drain_busy, 0);
    checkOutput("rdrain_fence_pass", hz.pc_en, 1);
    checkOutput("rdrain_no_bubble", hz.idex_flush, 0);

    // randomized traffic; the held ID instruction mimics a stalled IF-ID
    hold = 1'b0;
    cur_ins = NOP_W;
    cur_v = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      r    = ($urandom_range(0, 99) == 0);
      rd_x = ($urandom_range(0, 11) == 0);
      if (!hold) begin
        cur_v   = ($urandom_range(0, 9) < 8);
        cur_ins = rand_instr();
      end
      applyStimulus(r, cur_ins, cur_v, rd_x);
      hold = !exp_ifid && !r;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
